// File: rtl/coffee_pkg.sv
// Shared definitions for the water-level sensor encoder: FSM states, display
// codes and the thermometer-pattern helpers used by the classifier.
package coffee_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  localparam logic [2:0] CODE_L0    = 3'b000;
  localparam logic [2:0] CODE_L1    = 3'b001;
  localparam logic [2:0] CODE_L2    = 3'b010;
  localparam logic [2:0] CODE_L3    = 3'b011;
  localparam logic [2:0] CODE_FAULT = 3'b111;

  // A physically plausible level is a thermometer code filled from s1 upward.
  function automatic logic pattern_valid(input logic [2:0] filt);
    return (filt == 3'b000) || (filt == 3'b001) ||
           (filt == 3'b011) || (filt == 3'b111);
  endfunction

  function automatic logic [2:0] level_code(input logic [2:0] filt);
    logic [2:0] code;
    case (filt)
      3'b001:  code = CODE_L1;
      3'b011:  code = CODE_L2;
      3'b111:  code = CODE_L3;
      default: code = CODE_L0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One sensor input: two-flop synchronizer followed by a disagreement counter
// that flips the filtered bit after DEB_CYCLES consecutive mismatches.
module debounce_bit #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = '0;
    cnt_inc = cnt_q + CW'(1);
    if (sync2_q != filt_q) begin
      // The flip and the counter clear land on the same edge.
      if (cnt_inc == CW'(DEB_CYCLES)) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/cod_ersensores.sv
// Water-level encoder: debounces three level sensors, classifies the pattern
// and drives a registered display code with fault detection and change pulse.
//
//   state      | meaning
//   ST_OK      | pattern valid, code follows the level
//   ST_SUSPECT | pattern invalid, code frozen, counting invalid cycles
//   ST_FAULT   | invalid too long, code 111 and err until clr with valid pattern
module cod_ersensores
  import coffee_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int ERR_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s1,
  input  logic s2,
  input  logic s3,
  input  logic clr,
  output logic A,
  output logic B,
  output logic C,
  output logic err,
  output logic chg
);

  localparam int EW = $clog2(ERR_CYCLES + 1);

  logic [2:0]    filt;
  logic          valid;
  logic [2:0]    code;

  state_e        state_q, state_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;
  logic [EW-1:0] err_cnt_inc;
  logic [2:0]    abc_q, abc_d;
  logic [2:0]    abc_last_q, abc_last_d;
  logic          err_q, err_d;
  logic          chg_q, chg_d;

  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s1 (
    .clk(clk), .rst_n(rst_n), .raw(s1), .filt(filt[0])
  );
  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s2 (
    .clk(clk), .rst_n(rst_n), .raw(s2), .filt(filt[1])
  );
  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_s3 (
    .clk(clk), .rst_n(rst_n), .raw(s3), .filt(filt[2])
  );

  always_comb begin
    valid       = pattern_valid(filt);
    code        = level_code(filt);
    state_d     = state_q;
    err_cnt_d   = err_cnt_q;
    err_cnt_inc = err_cnt_q + EW'(1);
    abc_d       = abc_q;
    err_d       = err_q;

    case (state_q)
      ST_OK: begin
        if (valid) begin
          abc_d = code;
        end else if (ERR_CYCLES <= 1) begin
          state_d = ST_FAULT;
          abc_d   = CODE_FAULT;
          err_d   = 1'b1;
        end else begin
          state_d   = ST_SUSPECT;
          err_cnt_d = EW'(1);
        end
      end
      ST_SUSPECT: begin
        if (valid) begin
          state_d   = ST_OK;
          abc_d     = code;
          err_cnt_d = '0;
        end else if (err_cnt_inc == EW'(ERR_CYCLES)) begin
          state_d   = ST_FAULT;
          abc_d     = CODE_FAULT;
          err_d     = 1'b1;
          err_cnt_d = '0;
        end else begin
          err_cnt_d = err_cnt_inc;
        end
      end
      ST_FAULT: begin
        if (clr && valid) begin
          state_d = ST_OK;
          abc_d   = code;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d   = ST_OK;
        err_cnt_d = '0;
      end
    endcase

    // chg lags the code by one cycle, so compare against the previous code.
    abc_last_d = abc_q;
    chg_d      = (abc_q != abc_last_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OK;
      err_cnt_q  <= '0;
      abc_q      <= CODE_L0;
      abc_last_q <= CODE_L0;
      err_q      <= 1'b0;
      chg_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      abc_q      <= abc_d;
      abc_last_q <= abc_last_d;
      err_q      <= err_d;
      chg_q      <= chg_d;
    end
  end

  assign A   = abc_q[2];
  assign B   = abc_q[1];
  assign C   = abc_q[0];
  assign err = err_q;
  assign chg = chg_q;

endmodule

// File: tb/tb_cod_ersensores.sv
// Bench for cod_ersensores: directed vector table, hand-written timing and
// reset sequences, then random sensor activity against a behavioural model.
module tb_cod_ersensores;

  localparam int DEB = 4;
  localparam int ERR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, clr = 1'b0;
  logic A, B, C, err, chg;

  always #5 clk = ~clk;

  cod_ersensores #(.DEB_CYCLES(DEB), .ERR_CYCLES(ERR)) dut (
    .clk(clk), .rst_n(rst_n), .s1(s1), .s2(s2), .s3(s3), .clr(clr),
    .A(A), .B(B), .C(C), .err(err), .chg(chg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: raw sample history, filtered vector, fault tracking.
  logic [2:0] hist[$];
  logic [2:0] m_filt;
  int         m_inv_run;
  bit         m_fault;
  logic [2:0] m_abc, m_abc_prev;
  logic       m_chg;

  typedef struct {
    logic [2:0] s;
    logic       c;
    int         hold;
    logic [2:0] abc;
    logic       e;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit pat_ok(input logic [2:0] v);
    return (v == 3'd0) || (v == 3'd1) || (v == 3'd3) || (v == 3'd7);
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (DEB + 2) hist.push_back(3'b000);
    m_filt     = 3'b000;
    m_inv_run  = 0;
    m_fault    = 1'b0;
    m_abc      = 3'b000;
    m_abc_prev = 3'b000;
    m_chg      = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] raw, input logic c);
    logic new_chg;
    bit   all_diff;
    new_chg    = (m_abc != m_abc_prev);
    m_abc_prev = m_abc;
    if (m_fault) begin
      if (c && pat_ok(m_filt)) begin
        m_fault   = 1'b0;
        m_abc     = 3'($countones(m_filt));
        m_inv_run = 0;
      end
    end else if (pat_ok(m_filt)) begin
      m_abc     = 3'($countones(m_filt));
      m_inv_run = 0;
    end else begin
      m_inv_run++;
      if (m_inv_run >= ERR) begin
        m_fault   = 1'b1;
        m_abc     = 3'b111;
        m_inv_run = 0;
      end
    end
    m_chg = new_chg;
    // A filtered bit flips once its last DEB synchronized samples (raw delayed by two) all disagree.
    for (int i = 0; i < 3; i++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= DEB; j++)
        if (hist[hist.size() - 1 - j][i] == m_filt[i]) all_diff = 1'b0;
      if (all_diff) m_filt[i] = ~m_filt[i];
    end
    hist.push_back(raw);
    if (hist.size() > DEB + 4) void'(hist.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    model_edge({s3, s2, s1}, clr);
    cyc++;
    #1;
    check("model", 8'({A, B, C, err, chg}), 8'({m_abc, m_fault, m_chg}));
  endtask

  task automatic set_s(input logic [2:0] v);
    {s3, s2, s1} = v;
  endtask

  task automatic settle(input logic [2:0] v);
    set_s(v);
    repeat (14) step();
  endtask

  task automatic reset_now_and_release();
    #2 rst_n = 1'b0;
    #1 check("rst_async", 8'({A, B, C, err, chg}), 8'd0);
    set_s(3'b000);
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int chg_seen;

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 8'({A, B, C, err, chg}), 8'd0);
    rst_n = 1'b1;

    // Quiet inputs after reset release.
    chg_seen = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (chg) chg_seen++;
    end
    check("idle_abc_err", 8'({A, B, C, err}), 8'd0);
    check("idle_chg_count", 8'(chg_seen), 8'd0);

    // Clean step on s1: code after 2 + DEB + 1 edges, chg one edge later.
    set_s(3'b001);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("lat_abc", 8'({A, B, C}), (k >= 7) ? 8'd1 : 8'd0);
      check("lat_chg", 8'(chg), (k == 8) ? 8'd1 : 8'd0);
    end
    settle(3'b000);

    // Glitch on s1 shorter than the debounce window.
    set_s(3'b001);
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 3) set_s(3'b000);
      check("glitch", 8'({A, B, C, err, chg}), 8'd0);
    end

    // Vector table, each entry held long enough to settle.
    vt[0] = '{3'b000, 1'b0, 14, 3'b000, 1'b0};
    vt[1] = '{3'b001, 1'b0, 14, 3'b001, 1'b0};
    vt[2] = '{3'b011, 1'b0, 14, 3'b010, 1'b0};
    vt[3] = '{3'b111, 1'b0, 14, 3'b011, 1'b0};
    vt[4] = '{3'b101, 1'b0, 14, 3'b111, 1'b1};
    vt[5] = '{3'b011, 1'b0, 14, 3'b111, 1'b1};
    vt[6] = '{3'b011, 1'b1, 14, 3'b010, 1'b0};
    vt[7] = '{3'b010, 1'b1, 14, 3'b111, 1'b1};
    vt[8] = '{3'b000, 1'b1, 14, 3'b000, 1'b0};
    vt[9] = '{3'b001, 1'b0, 14, 3'b001, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_s(vt[i].s);
      clr = vt[i].c;
      repeat (vt[i].hold) step();
      check($sformatf("vec%0d_abc", i), 8'({A, B, C}), 8'(vt[i].abc));
      check($sformatf("vec%0d_err", i), 8'(err), 8'(vt[i].e));
      check($sformatf("vec%0d_chg", i), 8'(chg), 8'd0);
    end
    clr = 1'b0;

    // Level 2 into an invalid pattern: held code, then fault, then clr exit.
    settle(3'b011);
    set_s(3'b101);
    for (int k = 1; k <= 14; k++) begin
      step();
      check("flt_abc", 8'({A, B, C}), (k >= 9) ? 8'd7 : 8'd2);
      check("flt_err", 8'(err), (k >= 9) ? 8'd1 : 8'd0);
      check("flt_chg", 8'(chg), (k == 10) ? 8'd1 : 8'd0);
    end
    settle(3'b011);
    check("flt_noclr_abc", 8'({A, B, C}), 8'd7);
    check("flt_noclr_err", 8'(err), 8'd1);
    clr = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("clr_abc", 8'({A, B, C}), 8'd2);
      check("clr_err", 8'(err), 8'd0);
      check("clr_chg", 8'(chg), (k == 2) ? 8'd1 : 8'd0);
    end
    clr = 1'b0;

    // Filtered pattern invalid for only two cycles while sensors rise unevenly.
    settle(3'b000);
    set_s(3'b010);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 2) set_s(3'b011);
      check("short_inv_err", 8'(err), 8'd0);
      check("short_inv_abc", 8'({A, B, C}), (k >= 9) ? 8'd2 : 8'd0);
    end

    // Reset in the middle of SUSPECT.
    settle(3'b001);
    set_s(3'b101);
    repeat (7) step();
    check("pre_rst_suspect", 8'({A, B, C, err}), 8'b0010);
    reset_now_and_release();
    chg_seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (chg) chg_seen++;
    end
    check("post_rst1_abc", 8'({A, B, C, err}), 8'd0);
    check("post_rst1_chg", 8'(chg_seen), 8'd0);

    // Reset while in FAULT.
    settle(3'b001);
    set_s(3'b101);
    repeat (12) step();
    check("pre_rst_fault", 8'({A, B, C, err}), 8'b1111);
    reset_now_and_release();
    chg_seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (chg) chg_seen++;
    end
    check("post_rst2_abc", 8'({A, B, C, err}), 8'd0);
    check("post_rst2_chg", 8'(chg_seen), 8'd0);

    // Random sensor activity with random hold times and clear requests.
    for (int n = 0; n < 400; n++) begin
      set_s(3'($urandom_range(0, 7)));
      clr = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(1, 10)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
